// File: rtl/mem_port_arbiter.sv
// Shared memory-bus arbiter: sequences instruction-fetch (I) and data (D) accesses with a
// registered req/ack protocol. Define ARB_ROUND_ROBIN_EN to alternate grants on contention.
module mem_port_arbiter #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 own_d;     // current/last grant owner, 1 = D
  logic                 we_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 grant_d;
  logic                 timeout;
  logic                 start;

  // The owner register doubles as the last-grant record for round-robin.
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d = (i_req && d_req) ? !own_d : d_req;
`else
  assign grant_d = d_req;
`endif

  assign start   = (state == IDLE) && (i_req || d_req);
  assign timeout = (TIMEOUT_CYCLES != 0) && !inputReady && (cnt == CNT_LAST);
  assign busy    = (state != IDLE);
  assign data    = writeM ? wdata_q : {WORD_SIZE{1'bz}};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = ACCESS;
      ACCESS:  if (inputReady || timeout) state_nxt = RELEASE;
      RELEASE: if (!inputReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      own_d   <= 1'b1;
      we_q    <= 1'b0;
      wdata_q <= '0;
      readM   <= 1'b0;
      writeM  <= 1'b0;
      address <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (start) begin
        own_d   <= grant_d;
        we_q    <= grant_d && d_we;
        wdata_q <= d_wdata;
        address <= grant_d ? d_addr : i_addr;
        readM   <= !(grant_d && d_we);
        writeM  <= grant_d && d_we;
        cnt     <= '0;
      end
      if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
        if (inputReady || timeout) begin
          readM  <= 1'b0;
          writeM <= 1'b0;
          if (timeout) err <= 1'b1;
          if (own_d) d_ack <= 1'b1;
          else       i_ack <= 1'b1;
          // Timed-out reads return all-ones so software can spot the dead access.
          if (!we_q) begin
            if (own_d) d_rdata <= timeout ? '1 : data;
            else       i_rdata <= timeout ? '1 : data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table vectors, contention/reset/idle sequences, and random
// transactions checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int T = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0, reset = 1'b1;
  logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, inputReady = 1'b0;
  logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic         i_ack, d_ack, readM, writeM, busy, err;
  logic [W-1:0] i_rdata, d_rdata, address;
  wire  [W-1:0] data;
  logic         mem_drv = 1'b0;
  logic [W-1:0] mem_dout = '0;

  int checks = 0, errors = 0;
  logic [W-1:0] m_i_rdata = '0, m_d_rdata = '0;
  logic         m_err = 1'b0, m_last_d = 1'b1;

  assign data = mem_drv ? mem_dout : 'z;
  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .busy(busy), .err(err)
  );

  typedef struct {
    logic         wi, wd, we;
    logic [W-1:0] ia, da, dwd, mrd;
    int           lat, hold;
    logic         x_wd;
    logic [W-1:0] x_rd;
    logic         x_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; the next posedge samples the requests.
  // Memory raises inputReady so that it is sampled at edge 'lat' and holds it 'hold' more edges.
  task automatic run_txn(input logic wi, input logic wd, input logic dwe,
                         input logic [W-1:0] ia, input logic [W-1:0] da,
                         input logic [W-1:0] dwd, input logic [W-1:0] mrd,
                         input int lat, input int hold,
                         input logic x_wd, input logic [W-1:0] x_rd, input logic x_err);
    int k, last_c;
    logic to, we_w;
    logic [W-1:0] a_w;
    to     = (lat > T);
    k      = to ? T : lat;
    last_c = k + 2 + (to ? 0 : hold);
    we_w   = x_wd && dwe;
    a_w    = x_wd ? da : ia;
    i_req = wi; i_addr = ia; d_req = wd; d_we = dwe; d_addr = da; d_wdata = dwd;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c <= k) begin
        chk("readM", 32'(readM), 32'(!we_w));
        chk("writeM", 32'(writeM), 32'(we_w));
        chk("address", 32'(address), 32'(a_w));
        chk("busy_access", 32'(busy), 32'd1);
        chk("ack_early", 32'({i_ack, d_ack}), 32'd0);
        if (we_w) chk("write_data_bus", 32'(data), 32'(dwd));
      end else if (c == k + 1) begin
        chk("ack_owner", 32'({i_ack, d_ack}), x_wd ? 32'd1 : 32'd2);
        chk("strobes_off", 32'({readM, writeM}), 32'd0);
        chk("busy_release", 32'(busy), 32'd1);
        chk("i_rdata", 32'(i_rdata), 32'(x_wd ? m_i_rdata : x_rd));
        chk("d_rdata", 32'(d_rdata), 32'(x_wd ? x_rd : m_d_rdata));
        chk("err", 32'(err), 32'(x_err));
        if (x_wd) d_req = 1'b0; else i_req = 1'b0;
      end else if (c < last_c) begin
        chk("busy_hold", 32'(busy), 32'd1);
        chk("ack_single", 32'({i_ack, d_ack}), 32'd0);
      end else begin
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ack_idle", 32'({i_ack, d_ack}), 32'd0);
        chk("strobes_idle", 32'({readM, writeM}), 32'd0);
        chk("err_sticky", 32'(err), 32'(x_err));
      end
      inputReady = !to && (c >= lat) && (c <= lat + hold);
      mem_drv    = inputReady && !we_w;
      mem_dout   = mrd;
    end
    if (x_wd) m_d_rdata = x_rd; else m_i_rdata = x_rd;
    m_err    = x_err;
    m_last_d = x_wd;
  endtask

  // Transaction-level reference: pick the winner and its result from the arbitration rules.
  task automatic model_txn(input logic wi, input logic wd, input logic dwe,
                           input logic [W-1:0] ia, input logic [W-1:0] da,
                           input logic [W-1:0] dwd, input logic [W-1:0] mrd,
                           input int lat, input int hold);
    logic win_d;
    logic [W-1:0] rd;
    if (wi && wd) win_d = RR ? !m_last_d : 1'b1;
    else          win_d = wd;
    if (win_d && dwe) rd = m_d_rdata;
    else if (lat > T) rd = '1;
    else              rd = mrd;
    run_txn(wi, wd, dwe, ia, da, dwd, mrd, lat, hold, win_d, rd, m_err || (lat > T));
  endtask

  initial begin
    logic         pi, pd, wi, wd, rwe;
    logic [W-1:0] ri, rdd, rdw;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hA5A5, 3, 0, 1'b0, 16'hA5A5, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 16'h1234, 16'h0000, 2, 0, 1'b1, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0030, 16'h0000, 16'h5A5A, 1, 0, 1'b1, 16'h5A5A, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h1111, 4, 0, 1'b0, 16'h1111, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0050, 16'hBEEF, 16'h0000, 1, 5, 1'b1, 16'h5A5A, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h0000, 16'h2222, 2, 5, 1'b0, 16'h2222, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0070, 16'h0000, 16'h9999, 99, 0, 1'b1, 16'hFFFF, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, 16'h0000, 16'h3333, 1, 0, 1'b0, 16'h3333, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0090, 16'h7777, 16'h0000, 99, 0, 1'b1, 16'hFFFF, 1'b1};

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_strobes", 32'({readM, writeM}), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
    chk("rst_busy_err", 32'({busy, err}), 32'd0);
    reset = 1'b0;

    for (int r = 0; r < 9; r++)
      run_txn(tbl[r].wi, tbl[r].wd, tbl[r].we, tbl[r].ia, tbl[r].da, tbl[r].dwd, tbl[r].mrd,
              tbl[r].lat, tbl[r].hold, tbl[r].x_wd, tbl[r].x_rd, tbl[r].x_err);

    // Stray inputReady while idle must be ignored
    inputReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_ready_busy", 32'(busy), 32'd0);
      chk("idle_ready_ack", 32'({i_ack, d_ack}), 32'd0);
    end
    inputReady = 1'b0;

    // Two contention rounds; the loser keeps requesting and is served next
    for (int n = 0; n < 2; n++) begin
      model_txn(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, 16'h0000, 16'hC001 + 16'(2*n), 1, 0);
      model_txn(m_last_d, !m_last_d, 1'b0, 16'h0100, 16'h0200, 16'h0000, 16'hC002 + 16'(2*n), 2, 0);
    end

    // Reset during ACCESS aborts the access
    i_req = 1'b1; i_addr = 16'h0AAA;
    @(negedge clk);
    chk("pre_reset_readM", 32'(readM), 32'd1);
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("abort_strobes", 32'({readM, writeM}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'({i_ack, d_ack}), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_rdata", 32'({i_rdata, d_rdata}), 32'd0);
    reset = 1'b0;
    m_i_rdata = '0; m_d_rdata = '0; m_err = 1'b0; m_last_d = 1'b1;
    model_txn(1'b1, 1'b0, 1'b0, 16'h0BBB, 16'h0000, 16'h0000, 16'h4444, 2, 1);

    // Random traffic; a contention loser stays pending with unchanged fields
    pi = 1'b0; pd = 1'b0; ri = '0; rdd = '0; rdw = '0; rwe = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!pi) ri = 16'($urandom);
      if (!pd) begin
        rdd = 16'($urandom); rdw = 16'($urandom); rwe = 1'($urandom);
      end
      wi = pi || 1'($urandom);
      wd = pd || 1'($urandom);
      if (!wi && !wd) wi = 1'b1;
      model_txn(wi, wd, rwe, ri, rdd, rdw, 16'($urandom),
                int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
      pi = wi && wd && m_last_d;
      pd = wi && wd && !m_last_d;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
